// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared definitions for the memory-port-2 bus arbiter.
//   - default parameter values for mem_bus_arbiter
//   - arbiter FSM state encoding
//   - helper that sizes the CPU quantum counter
package mem_bus_pkg;

    localparam int unsigned WORD_SIZE_DEF   = 16;
    localparam int unsigned CPU_QUANTUM_DEF = 4;
    localparam int unsigned CNT_W_DEF       = 16;

    typedef enum logic [2:0] {
        ST_CPU,      // CPU owns port 2, DMA idle
        ST_DRAIN,    // DMA waiting for the CPU's in-flight access to finish
        ST_DMA,      // DMA owns the bus
        ST_TURN,     // one dead cycle between DMA release and CPU drive
        ST_QUANTUM   // CPU protected against immediate DMA re-grant
    } arb_state_e;

    // Width needed to count 0..q; never less than one bit so a zero
    // quantum still yields a legal vector.
    function automatic int unsigned qcnt_width(input int unsigned q);
        return (q < 1) ? 1 : $clog2(q + 1);
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_sat_counter.sv
// sat_counter: synchronous counter that sticks at all-ones.
//   clk   - clock, rising edge
//   clr   - synchronous clear (priority over inc)
//   inc   - add one this cycle unless already saturated
//   count - current value
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates memory port 2 between the CPU data side and
// a DMA controller (br/bg handshake), with a bus-turnaround cycle after
// every DMA release and a CPU fairness quantum.
//   clk, reset_n - clock and synchronous active-low reset
//   cpu_req      - CPU wants port 2 this cycle
//   cpu_busy     - CPU has a port-2 access in flight
//   br           - DMA bus request (level, held for whole transfer)
//   bg           - DMA bus grant (registered)
//   cpu_grant    - CPU may drive port 2 (registered)
//   cpu_stall    - cpu_req while not granted (combinational)
//   dma_grants   - completed DMA ownership periods (saturating)
//   dma_cycles   - cycles spent with bg=1 (saturating)
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = WORD_SIZE_DEF,
    parameter int unsigned CPU_QUANTUM = CPU_QUANTUM_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cpu_req,
    input  logic             cpu_busy,
    input  logic             br,
    output logic             bg,
    output logic             cpu_grant,
    output logic             cpu_stall,
    output logic [CNT_W-1:0] dma_grants,
    output logic [CNT_W-1:0] dma_cycles
);

    localparam int unsigned QCNT_W = qcnt_width(CPU_QUANTUM);
    localparam logic [QCNT_W-1:0] QLAST =
        QCNT_W'((CPU_QUANTUM == 0) ? 0 : CPU_QUANTUM - 1);

    // The arbiter moves no data; WORD_SIZE is kept for interface
    // compatibility with the surrounding memory system.
    if (WORD_SIZE < 1) begin : g_bad_word_size
        $error("mem_bus_arbiter: WORD_SIZE must be at least 1");
    end

    arb_state_e        state_q, state_d;
    logic [QCNT_W-1:0] qcnt_q,  qcnt_d;
    logic              bg_q,    bg_d;
    logic              cpu_grant_q, cpu_grant_d;

    logic dma_grant_inc;
    logic dma_cycle_inc;

    always_comb begin
        state_d = state_q;
        qcnt_d  = qcnt_q;
        unique case (state_q)
            ST_CPU: begin
                if (br) begin
                    state_d = cpu_busy ? ST_DRAIN : ST_DMA;
                end
            end
            ST_DRAIN: begin
                if (!br) begin
                    state_d = ST_CPU;
                end else if (!cpu_busy) begin
                    state_d = ST_DMA;
                end
            end
            ST_DMA: begin
                // cpu_busy is deliberately not looked at here.
                if (!br) begin
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                if (cpu_req && (CPU_QUANTUM != 0)) begin
                    state_d = ST_QUANTUM;
                    qcnt_d  = '0;
                end else begin
                    state_d = ST_CPU;
                end
            end
            ST_QUANTUM: begin
                // qcnt counts completed quantum cycles; leaving on QLAST
                // gives exactly CPU_QUANTUM cycles in this state.
                if ((!cpu_req && !cpu_busy) || (qcnt_q == QLAST)) begin
                    state_d = ST_CPU;
                    qcnt_d  = '0;
                end else begin
                    qcnt_d = qcnt_q + QCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_CPU;
                qcnt_d  = '0;
            end
        endcase

        // Grants are decoded from the next state so they register
        // together with it.
        bg_d        = (state_d == ST_DMA);
        cpu_grant_d = (state_d == ST_CPU) || (state_d == ST_DRAIN) ||
                      (state_d == ST_QUANTUM);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_CPU;
            qcnt_q      <= '0;
            bg_q        <= 1'b0;
            cpu_grant_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            bg_q        <= bg_d;
            cpu_grant_q <= cpu_grant_d;
        end
    end

    // Reset drives the counters' clear, which dominates inc, so a reset
    // taken mid-DMA records neither a grant nor the final cycle.
    assign dma_grant_inc = (state_q == ST_DMA) && !br;
    assign dma_cycle_inc = (state_q == ST_DMA);

    sat_counter #(.WIDTH(CNT_W)) u_grant_cnt (
        .clk   (clk),
        .clr   (~reset_n),
        .inc   (dma_grant_inc),
        .count (dma_grants)
    );

    sat_counter #(.WIDTH(CNT_W)) u_cycle_cnt (
        .clk   (clk),
        .clr   (~reset_n),
        .inc   (dma_cycle_inc),
        .count (dma_cycles)
    );

    assign bg        = bg_q;
    assign cpu_grant = cpu_grant_q;
    assign cpu_stall = cpu_req & ~cpu_grant_q;

endmodule
